// File: rtl/geared_mem_port.sv
// geared_mem_port: single-clock gearbox from one full-rate memory port to
// NumLanes slow lanes, each sampled once every GearRatio cycles.
// Requests are spread round-robin across the lanes. Responses are buffered
// per lane and returned upstream in issue order. A credit limit bounds the
// number of outstanding transactions, so the lanes never see back-pressure.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   req_i/gnt_o              upstream request handshake
//   addr_i/we_i/wdata_i/strb_i  upstream request payload
//   rvalid_o/rdata_o         upstream response (always accepted)
//   phase_o                  slow-cycle sample strobe
//   lane_req_o/lane_gnt_i    per-lane request handshake
//   lane_addr_o/lane_we_o/lane_wdata_o/lane_strb_o  per-lane payload
//   lane_rvalid_i/lane_rdata_i  per-lane response
// Optional: GEARED_MEM_PORT_RSP_FALLTHROUGH_EN presents a response in the
// same cycle it becomes available instead of one cycle later.
module geared_mem_port #(
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 64,
    parameter int GearRatio      = 2,
    parameter int NumLanes       = GearRatio,
    parameter int MaxOutstanding = 4,
    localparam int StrbWidth     = DataWidth / 8,
    localparam int RspDepth      = MaxOutstanding
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           req_i,
    output logic                           gnt_o,
    input  logic [AddrWidth-1:0]           addr_i,
    input  logic                           we_i,
    input  logic [DataWidth-1:0]           wdata_i,
    input  logic [StrbWidth-1:0]           strb_i,
    output logic                           rvalid_o,
    output logic [DataWidth-1:0]           rdata_o,
    output logic                           phase_o,
    output logic [NumLanes-1:0]            lane_req_o,
    input  logic [NumLanes-1:0]            lane_gnt_i,
    output logic [NumLanes*AddrWidth-1:0]  lane_addr_o,
    output logic [NumLanes-1:0]            lane_we_o,
    output logic [NumLanes*DataWidth-1:0]  lane_wdata_o,
    output logic [NumLanes*StrbWidth-1:0]  lane_strb_o,
    input  logic [NumLanes-1:0]            lane_rvalid_i,
    input  logic [NumLanes*DataWidth-1:0]  lane_rdata_i
);

    localparam int PhW = (GearRatio > 1) ? $clog2(GearRatio) : 1;
    localparam int LW  = (NumLanes > 1) ? $clog2(NumLanes) : 1;
    localparam int OW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CW  = $clog2(MaxOutstanding + 1);
    localparam int RW  = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int RCW = $clog2(RspDepth + 1);

    logic [PhW-1:0]               r_cnt;
    logic [NumLanes-1:0]          r_lvld;
    logic [NumLanes*AddrWidth-1:0] r_laddr;
    logic [NumLanes-1:0]          r_lwe;
    logic [NumLanes*DataWidth-1:0] r_lwdata;
    logic [NumLanes*StrbWidth-1:0] r_lstrb;
    logic [LW-1:0]                r_wptr;
    logic [LW-1:0]                r_ord [MaxOutstanding];
    logic [OW-1:0]                r_ord_wp;
    logic [OW-1:0]                r_ord_rp;
    logic [CW-1:0]                r_outst;
    logic [DataWidth-1:0]         r_rsp [NumLanes][RspDepth];
    logic [RW-1:0]                r_rwp [NumLanes];
    logic [RW-1:0]                r_rrp [NumLanes];
    logic [RCW-1:0]               r_rcnt [NumLanes];
    logic [DataWidth-1:0]         r_rdata;

    logic                 w_phase;
    logic                 w_acc;
    logic [NumLanes-1:0]  w_sel;
    logic [NumLanes-1:0]  w_cap;
    logic [NumLanes-1:0]  w_lclr;
    logic [LW-1:0]        w_head;
    logic                 w_rsp_ne;
    logic                 w_avail;
    logic [DataWidth-1:0] w_data;
    logic [NumLanes-1:0]  w_push;
    logic [NumLanes-1:0]  w_pop;

    function automatic logic [OW-1:0] ord_inc(input logic [OW-1:0] p);
        return (p == OW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [RW-1:0] rsp_inc(input logic [RW-1:0] p);
        return (p == RW'(RspDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_phase = (r_cnt == PhW'(GearRatio - 1));
    assign gnt_o   = req_i && !r_lvld[r_wptr] && (r_outst < CW'(MaxOutstanding));
    assign w_acc   = req_i && gnt_o;
    assign w_sel   = NumLanes'(1) << r_wptr;
    assign w_cap   = {NumLanes{w_phase}} & lane_rvalid_i;
    assign w_lclr  = {NumLanes{w_phase}} & r_lvld & lane_gnt_i;

    // The order FIFO holds exactly r_outst entries, so r_outst doubles as
    // its occupancy.
    assign w_head   = r_ord[r_ord_rp];
    assign w_rsp_ne = (r_rcnt[w_head] != '0);
    assign w_avail  = (r_outst != '0) && (w_rsp_ne || w_cap[w_head]);
    assign w_data   = w_rsp_ne ? r_rsp[w_head][r_rrp[w_head]]
                               : lane_rdata_i[w_head*DataWidth +: DataWidth];

    // A capture for the head lane into an empty buffer is consumed
    // directly and never stored.
    always_comb begin
        w_push = w_cap;
        w_pop  = '0;
        if (w_avail) begin
            if (w_rsp_ne) w_pop[w_head] = 1'b1;
            else          w_push[w_head] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      r_cnt <= '0;
        else if (w_phase) r_cnt <= '0;
        else              r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lvld   <= '0;
            r_laddr  <= '0;
            r_lwe    <= '0;
            r_lwdata <= '0;
            r_lstrb  <= '0;
            r_wptr   <= '0;
            r_ord_wp <= '0;
            r_ord_rp <= '0;
            r_outst  <= '0;
        end else begin
            r_lvld <= (r_lvld & ~w_lclr) | (w_acc ? w_sel : '0);
            if (w_acc) begin
                r_laddr[r_wptr*AddrWidth +: AddrWidth]  <= addr_i;
                r_lwe[r_wptr]                           <= we_i;
                r_lwdata[r_wptr*DataWidth +: DataWidth] <= wdata_i;
                r_lstrb[r_wptr*StrbWidth +: StrbWidth]  <= strb_i;
                r_wptr   <= (r_wptr == LW'(NumLanes - 1)) ? '0 : r_wptr + 1'b1;
                r_ord_wp <= ord_inc(r_ord_wp);
            end
            if (w_avail) r_ord_rp <= ord_inc(r_ord_rp);
            case ({w_acc, w_avail})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_acc) r_ord[r_ord_wp] <= r_wptr;
        for (int l = 0; l < NumLanes; l++) begin
            if (w_push[l]) r_rsp[l][r_rwp[l]] <= lane_rdata_i[l*DataWidth +: DataWidth];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < NumLanes; l++) begin
                r_rwp[l]  <= '0;
                r_rrp[l]  <= '0;
                r_rcnt[l] <= '0;
            end
        end else begin
            for (int l = 0; l < NumLanes; l++) begin
                if (w_push[l]) r_rwp[l] <= rsp_inc(r_rwp[l]);
                if (w_pop[l])  r_rrp[l] <= rsp_inc(r_rrp[l]);
                case ({w_push[l], w_pop[l]})
                    2'b10:   r_rcnt[l] <= r_rcnt[l] + 1'b1;
                    2'b01:   r_rcnt[l] <= r_rcnt[l] - 1'b1;
                    default: r_rcnt[l] <= r_rcnt[l];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      r_rdata <= '0;
        else if (w_avail) r_rdata <= w_data;
    end

`ifdef GEARED_MEM_PORT_RSP_FALLTHROUGH_EN
    assign rvalid_o = w_avail;
    assign rdata_o  = w_avail ? w_data : r_rdata;
`else
    logic r_rvalid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_rvalid <= 1'b0;
        else         r_rvalid <= w_avail;
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
`endif

    assign phase_o      = w_phase;
    assign lane_req_o   = r_lvld;
    assign lane_addr_o  = r_laddr;
    assign lane_we_o    = r_lwe;
    assign lane_wdata_o = r_lwdata;
    assign lane_strb_o  = r_lstrb;

    // Lane responses must match an outstanding request and fit the buffer.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            if (|w_cap) assert (r_outst != '0);
            for (int l = 0; l < NumLanes; l++) begin
                if (w_push[l]) assert (r_rcnt[l] != RCW'(RspDepth) || w_pop[l]);
            end
        end
    end

endmodule

// File: tb/tb_geared_mem_port.sv
// tb_geared_mem_port: directed checks of geared_mem_port with
// GearRatio=4, NumLanes=2, MaxOutstanding=4.
module tb_geared_mem_port;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = 8;
    localparam int GR = 4;
    localparam int NL = 2;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req = 1'b0;
    logic gnt;
    logic [AW-1:0] addr = '0;
    logic we = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] strb = '0;
    logic rvalid;
    logic [DW-1:0] rdata;
    logic phase;
    logic [NL-1:0] lreq;
    logic [NL-1:0] lgnt = '0;
    logic [NL*AW-1:0] laddr;
    logic [NL-1:0] lwe;
    logic [NL*DW-1:0] lwdata;
    logic [NL*SW-1:0] lstrb;
    logic [NL-1:0] lrv = '0;
    logic [NL*DW-1:0] lrdata = '0;

    int ntests = 0;
    int nfail = 0;
    int ph;

    always #5 clk = ~clk;

    // Expected phase count, kept independently of the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ph <= 0;
        else        ph <= (ph == GR - 1) ? 0 : ph + 1;
    end

    geared_mem_port #(
        .AddrWidth(AW), .DataWidth(DW), .GearRatio(GR),
        .NumLanes(NL), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
        .wdata_i(wdata), .strb_i(strb),
        .rvalid_o(rvalid), .rdata_o(rdata), .phase_o(phase),
        .lane_req_o(lreq), .lane_gnt_i(lgnt), .lane_addr_o(laddr),
        .lane_we_o(lwe), .lane_wdata_o(lwdata), .lane_strb_o(lstrb),
        .lane_rvalid_i(lrv), .lane_rdata_i(lrdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic to_phase();
        for (int i = 0; i < GR; i++) if (ph != GR - 1) step();
    endtask

    task automatic do_reset();
        req = 0; we = 0; strb = '0; wdata = '0; lgnt = '0; lrv = '0;
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        step();
        mid();
        ntests++;
        if ({gnt, rvalid, lreq, phase} !== 5'b0) begin
            nfail++;
            $display("FAIL reset_out: got gnt=%0b rv=%0b lreq=%b ph=%0b want 0", gnt, rvalid, lreq, phase);
        end
        step();
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            mid();
            ntests++;
            if (phase !== (ph == GR - 1)) begin
                nfail++;
                $display("FAIL phase_%0d: got %0b want %0b", i, phase, (ph == GR - 1));
            end
            step();
        end
    endtask

    task automatic test_single_read();
        do_reset();
        step();
        req = 1; addr = 32'h40;
        mid();
        ntests++;
        if (gnt !== 1'b1) begin nfail++; $display("FAIL sr_gnt: got %0b want 1", gnt); end
        step();
        req = 0; addr = '0;
        mid();
        ntests++;
        if (lreq !== 2'b01 || laddr[31:0] !== 32'h40) begin
            nfail++; $display("FAIL sr_lreq: got %b/%h want 01/40", lreq, laddr[31:0]);
        end
        step();
        lgnt = 2'b01;
        mid();
        ntests++;
        if (phase !== 1'b1 || lreq !== 2'b01) begin
            nfail++; $display("FAIL sr_phase: got ph=%0b lreq=%b want 1/01", phase, lreq);
        end
        step();
        lgnt = 2'b00;
        mid();
        ntests++;
        if (lreq !== 2'b00) begin nfail++; $display("FAIL sr_clr: got %b want 00", lreq); end
        to_phase();
        lrv = 2'b01; lrdata[63:0] = 64'hA5;
        mid();
        ntests++;
        if (rvalid !== 1'b0) begin nfail++; $display("FAIL sr_rv_early: got %0b want 0", rvalid); end
        step();
        lrv = 2'b00; lrdata = '0;
        mid();
        ntests++;
        if (rvalid !== 1'b1 || rdata !== 64'hA5) begin
            nfail++; $display("FAIL sr_rsp: got %0b/%h want 1/a5", rvalid, rdata);
        end
        step();
        mid();
        ntests++;
        if (rvalid !== 1'b0 || rdata !== 64'hA5) begin
            nfail++; $display("FAIL sr_hold: got %0b/%h want 0/a5", rvalid, rdata);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 1; addr = 32'h100;
        mid();
        ntests++;
        if (gnt !== 1'b1) begin nfail++; $display("FAIL rr_gnt0: got %0b want 1", gnt); end
        step();
        addr = 32'h104;
        mid();
        ntests++;
        if (gnt !== 1'b1) begin nfail++; $display("FAIL rr_gnt1: got %0b want 1", gnt); end
        step();
        addr = 32'h108;
        mid();
        ntests++;
        if (gnt !== 1'b0) begin nfail++; $display("FAIL rr_stall: got %0b want 0", gnt); end
        step();
        lgnt = 2'b11;
        mid();
        ntests++;
        if (gnt !== 1'b0 || laddr !== {32'h104, 32'h100}) begin
            nfail++; $display("FAIL rr_lanes01: got gnt=%0b addr=%h want 0/0000010400000100", gnt, laddr);
        end
        step();
        lgnt = 2'b00;
        mid();
        ntests++;
        if (gnt !== 1'b1 || lreq !== 2'b00) begin
            nfail++; $display("FAIL rr_resume: got gnt=%0b lreq=%b want 1/00", gnt, lreq);
        end
        step();
        addr = 32'h10C;
        mid();
        ntests++;
        if (gnt !== 1'b1 || lreq !== 2'b01 || laddr[31:0] !== 32'h108) begin
            nfail++; $display("FAIL rr_lane0b: got gnt=%0b lreq=%b a=%h want 1/01/108", gnt, lreq, laddr[31:0]);
        end
        step();
        req = 0;
        mid();
        ntests++;
        if (lreq !== 2'b11 || laddr[63:32] !== 32'h10C) begin
            nfail++; $display("FAIL rr_lane1b: got lreq=%b a=%h want 11/10c", lreq, laddr[63:32]);
        end
    endtask

    task automatic test_reorder();
        do_reset();
        req = 1; addr = 32'h200;
        step();
        addr = 32'h204;
        step();
        req = 0;
        to_phase();
        lgnt = 2'b11;
        step();
        lgnt = 2'b00;
        to_phase();
        lrv = 2'b10; lrdata[127:64] = 64'h22;
        mid();
        ntests++;
        if (rvalid !== 1'b0) begin nfail++; $display("FAIL ro_early: got %0b want 0", rvalid); end
        step();
        lrv = 2'b00;
        mid();
        ntests++;
        if (rvalid !== 1'b0) begin nfail++; $display("FAIL ro_wait: got %0b want 0", rvalid); end
        to_phase();
        lrv = 2'b01; lrdata[63:0] = 64'h11;
        step();
        lrv = 2'b00;
        mid();
        ntests++;
        if (rvalid !== 1'b1 || rdata !== 64'h11) begin
            nfail++; $display("FAIL ro_first: got %0b/%h want 1/11", rvalid, rdata);
        end
        step();
        mid();
        ntests++;
        if (rvalid !== 1'b1 || rdata !== 64'h22) begin
            nfail++; $display("FAIL ro_second: got %0b/%h want 1/22", rvalid, rdata);
        end
        step();
        mid();
        ntests++;
        if (rvalid !== 1'b0) begin nfail++; $display("FAIL ro_done: got %0b want 0", rvalid); end
    endtask

    task automatic test_credit();
        do_reset();
        req = 1; addr = 32'h300;
        step();
        addr = 32'h304;
        step();
        addr = 32'h308;
        step();
        lgnt = 2'b11;
        step();
        lgnt = 2'b00;
        mid();
        ntests++;
        if (gnt !== 1'b1) begin nfail++; $display("FAIL cr_third: got %0b want 1", gnt); end
        step();
        addr = 32'h30C;
        step();
        addr = 32'h310;
        step();
        lgnt = 2'b11;
        step();
        lgnt = 2'b00;
        mid();
        ntests++;
        if (gnt !== 1'b0 || lreq !== 2'b00) begin
            nfail++; $display("FAIL cr_limit: got gnt=%0b lreq=%b want 0/00", gnt, lreq);
        end
        to_phase();
        lrv = 2'b01; lrdata[63:0] = 64'h33;
        mid();
        ntests++;
        if (gnt !== 1'b0) begin nfail++; $display("FAIL cr_still: got %0b want 0", gnt); end
        step();
        lrv = 2'b00;
        mid();
        ntests++;
        if (rvalid !== 1'b1 || rdata !== 64'h33 || gnt !== 1'b1) begin
            nfail++; $display("FAIL cr_release: got rv=%0b d=%h gnt=%0b want 1/33/1", rvalid, rdata, gnt);
        end
        step();
        req = 0;
        mid();
        ntests++;
        if (lreq !== 2'b01 || laddr[31:0] !== 32'h310) begin
            nfail++; $display("FAIL cr_issue: got lreq=%b a=%h want 01/310", lreq, laddr[31:0]);
        end
    endtask

    task automatic test_write();
        do_reset();
        req = 1; we = 1; addr = 32'h80; wdata = 64'hDEADBEEF01234567; strb = 8'hF0;
        mid();
        ntests++;
        if (gnt !== 1'b1) begin nfail++; $display("FAIL wr_gnt: got %0b want 1", gnt); end
        step();
        req = 0; we = 0; strb = '0; wdata = '0;
        for (int i = 0; i < 6; i++) begin
            mid();
            ntests++;
            if (lreq !== 2'b01 || lwe[0] !== 1'b1 || lstrb[7:0] !== 8'hF0 ||
                lwdata[63:0] !== 64'hDEADBEEF01234567) begin
                nfail++;
                $display("FAIL wr_hold_%0d: got lreq=%b we=%0b st=%h d=%h want 01/1/f0/deadbeef01234567",
                         i, lreq, lwe[0], lstrb[7:0], lwdata[63:0]);
            end
            step();
        end
        lgnt = 2'b01;
        mid();
        ntests++;
        if (phase !== 1'b1 || lwe[0] !== 1'b1) begin
            nfail++; $display("FAIL wr_phase: got ph=%0b we=%0b want 1/1", phase, lwe[0]);
        end
        step();
        lgnt = 2'b00;
        mid();
        ntests++;
        if (lreq !== 2'b00) begin nfail++; $display("FAIL wr_clr: got %b want 00", lreq); end
        to_phase();
        lrv = 2'b01; lrdata[63:0] = 64'h0;
        step();
        lrv = 2'b00;
        mid();
        ntests++;
        if (rvalid !== 1'b1) begin nfail++; $display("FAIL wr_rsp: got %0b want 1", rvalid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 1; addr = 32'h400;
        step();
        addr = 32'h404;
        step();
        addr = 32'h408;
        step();
        lgnt = 2'b11;
        step();
        lgnt = 2'b00;
        step();
        req = 0;
        mid();
        ntests++;
        if (lreq !== 2'b01) begin nfail++; $display("FAIL rm_pre: got %b want 01", lreq); end
        step();
        rst_n = 0;
        mid();
        ntests++;
        if (lreq !== 2'b00 || rvalid !== 1'b0 || gnt !== 1'b0 || phase !== 1'b0) begin
            nfail++; $display("FAIL rm_reset: got lreq=%b rv=%0b gnt=%0b ph=%0b want 00/0/0/0", lreq, rvalid, gnt, phase);
        end
        step();
        rst_n = 1;
        req = 1; addr = 32'h99;
        mid();
        ntests++;
        if (gnt !== 1'b1) begin nfail++; $display("FAIL rm_gnt: got %0b want 1", gnt); end
        step();
        req = 0;
        mid();
        ntests++;
        if (lreq !== 2'b01 || laddr[31:0] !== 32'h99 || rvalid !== 1'b0) begin
            nfail++; $display("FAIL rm_issue: got lreq=%b a=%h rv=%0b want 01/99/0", lreq, laddr[31:0], rvalid);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_reorder();
        test_credit();
        test_write();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1, "timeout");
    end

endmodule
